// File: rtl/d_reg_pkg.sv
// Mode encoding shared by the D-register pipeline, its stages and its users.
package d_reg_pkg;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_SHIFT = 2'b01;
  localparam logic [1:0] MODE_LOAD  = 2'b10;
  localparam logic [1:0] MODE_CLEAR = 2'b11;

endpackage

// File: rtl/d_reg_pipe_if.sv
// Control/data bundle of the D-register pipeline: the master drives the
// command side (en, mode, D, in_valid), the slave returns stage status.
interface d_reg_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] D;
  logic             in_valid;
  logic [WIDTH-1:0] Q;
  logic             out_valid;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;

  modport master (
    output en, mode, D, in_valid,
    input  Q, out_valid, count, full, empty
  );

  modport slave (
    input  en, mode, D, in_valid,
    output Q, out_valid, count, full, empty
  );
endinterface

// File: rtl/d_reg_stage.sv
// One pipeline stage: WIDTH-bit data register plus its valid bit.
// clr wins over ld; with neither asserted the stage holds.
module d_reg_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             Rst,
  input  logic             ld,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             v_in,
  output logic [WIDTH-1:0] q,
  output logic             v
);

  // Stage register: async clear on Rst low, otherwise clear/load/hold.
  always_ff @(posedge clock or negedge Rst) begin
    if (!Rst) begin
      q <= '0;
      v <= 1'b0;
    end else if (clr) begin
      q <= '0;
      v <= 1'b0;
    end else if (ld) begin
      q <= d;
      v <= v_in;
    end
  end

endmodule

// File: rtl/d_reg_pipe.sv
// WIDTH-bit, DEPTH-stage D-register pipeline with per-stage valid bits.
// Decodes en/mode into per-stage load/clear strobes and keeps a registered
// occupancy count (with full/empty flags) in step with the stage valids.
module d_reg_pipe
  import d_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic           clock,
  input logic           Rst,
  d_reg_pipe_if.slave   bus
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] stage_q   [DEPTH];
  logic             stage_v   [DEPTH];
  logic [WIDTH-1:0] stage_d   [DEPTH];
  logic             stage_vin [DEPTH];
  logic             ld;
  logic             clr;

  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count_next;
  logic [CW:0]      count_ext;

  // Mode decode: en low or an unrecognised mode leaves every stage holding.
  always_comb begin
    ld         = 1'b0;
    clr        = 1'b0;
    count_next = count;
    count_ext  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      stage_d[i]   = bus.D;
      stage_vin[i] = bus.in_valid;
    end
    if (bus.en) begin
      case (bus.mode)
        MODE_SHIFT: begin
          ld = 1'b1;
          for (int i = 1; i < DEPTH; i++) begin
            stage_d[i]   = stage_q[i-1];
            stage_vin[i] = stage_v[i-1];
          end
          // Occupancy moves by what enters stage 0 minus what leaves the end.
          count_ext  = {1'b0, count} + {{CW{1'b0}}, bus.in_valid}
                     - {{CW{1'b0}}, stage_v[DEPTH-1]};
          count_next = count_ext[CW-1:0];
        end
        MODE_LOAD: begin
          ld         = 1'b1;
          count_next = bus.in_valid ? CW'(DEPTH) : '0;
        end
        MODE_CLEAR: begin
          clr        = 1'b1;
          count_next = '0;
        end
        default: ;
      endcase
    end
  end

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_stage
      d_reg_stage #(.WIDTH(WIDTH)) u_stage (
        .clock (clock),
        .Rst   (Rst),
        .ld    (ld),
        .clr   (clr),
        .d     (stage_d[g]),
        .v_in  (stage_vin[g]),
        .q     (stage_q[g]),
        .v     (stage_v[g])
      );
    end
  endgenerate

  // Occupancy and flags, registered on the same edge as the stages.
  always_ff @(posedge clock or negedge Rst) begin
    if (!Rst) begin
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  // An unknown mode while enabled is a stimulus error; flag it.
  always_ff @(posedge clock) begin
    if (Rst && bus.en === 1'b1) begin
      assert (!$isunknown(bus.mode))
        else $error("d_reg_pipe: mode is unknown while enabled");
    end
  end

  assign bus.Q         = stage_q[DEPTH-1];
  assign bus.out_valid = stage_v[DEPTH-1];
  assign bus.count     = count;
  assign bus.full      = full;
  assign bus.empty     = empty;

endmodule

// File: tb/tb_d_reg_pipe.sv
// Directed bench for d_reg_pipe (WIDTH=8, DEPTH=4).
module tb_d_reg_pipe;
  import d_reg_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  d_reg_pipe_if #(.WIDTH(8), .DEPTH(4)) bus ();

  d_reg_pipe #(.WIDTH(8), .DEPTH(4)) dut (
    .clock (clk),
    .Rst   (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] q, input logic ov,
                         input logic [2:0] cnt, input logic fl, input logic em);
    chk({tag, ".Q"},         32'(bus.Q),         32'(q));
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
    chk({tag, ".count"},     32'(bus.count),     32'(cnt));
    chk({tag, ".full"},      32'(bus.full),      32'(fl));
    chk({tag, ".empty"},     32'(bus.empty),     32'(em));
  endtask

  // Apply one command, take one rising edge, sample 1 time unit later.
  task automatic step(input logic e, input logic [1:0] m, input logic [7:0] d, input logic v);
    bus.en       = e;
    bus.mode     = m;
    bus.D        = d;
    bus.in_valid = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.mode     = MODE_HOLD;
    bus.D        = '0;
    bus.in_valid = 1'b0;

    // Reset state
    @(posedge clk); #1;
    chk_all("reset", 8'h00, 1'b0, 3'd0, 1'b0, 1'b1);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Latency: single valid A5 followed by bubbles
    step(1'b1, MODE_SHIFT, 8'hA5, 1'b1);
    chk_all("lat1", 8'h00, 1'b0, 3'd1, 1'b0, 1'b0);
    step(1'b1, MODE_SHIFT, 8'h00, 1'b0);
    chk_all("lat2", 8'h00, 1'b0, 3'd1, 1'b0, 1'b0);
    step(1'b1, MODE_SHIFT, 8'h00, 1'b0);
    chk_all("lat3", 8'h00, 1'b0, 3'd1, 1'b0, 1'b0);
    step(1'b1, MODE_SHIFT, 8'h00, 1'b0);
    chk_all("lat4", 8'hA5, 1'b1, 3'd1, 1'b0, 1'b0);
    step(1'b1, MODE_SHIFT, 8'h00, 1'b0);
    chk_all("lat5", 8'h00, 1'b0, 3'd0, 1'b0, 1'b1);

    // Fill with 1..5
    step(1'b1, MODE_SHIFT, 8'd1, 1'b1);
    step(1'b1, MODE_SHIFT, 8'd2, 1'b1);
    step(1'b1, MODE_SHIFT, 8'd3, 1'b1);
    chk_all("fill3", 8'h00, 1'b0, 3'd3, 1'b0, 1'b0);
    step(1'b1, MODE_SHIFT, 8'd4, 1'b1);
    chk_all("fill4", 8'd1, 1'b1, 3'd4, 1'b1, 1'b0);
    step(1'b1, MODE_SHIFT, 8'd5, 1'b1);
    chk_all("fill5", 8'd2, 1'b1, 3'd4, 1'b1, 1'b0);

    // Bubble leaving a full pipe drops count by one
    step(1'b1, MODE_SHIFT, 8'h77, 1'b0);
    chk_all("bubble", 8'd3, 1'b1, 3'd3, 1'b0, 1'b0);

    // HOLD: no change
    step(1'b1, MODE_HOLD, 8'hFF, 1'b1);
    chk_all("hold", 8'd3, 1'b1, 3'd3, 1'b0, 1'b0);

    // LOAD then CLEAR
    step(1'b1, MODE_LOAD, 8'h3C, 1'b1);
    chk_all("load", 8'h3C, 1'b1, 3'd4, 1'b1, 1'b0);
    step(1'b1, MODE_CLEAR, 8'h99, 1'b1);
    chk_all("clear", 8'h00, 1'b0, 3'd0, 1'b0, 1'b1);

    // LOAD with in_valid=0: data visible but unqualified
    step(1'b1, MODE_LOAD, 8'h5A, 1'b0);
    chk_all("load_inv", 8'h5A, 1'b0, 3'd0, 1'b0, 1'b1);
    step(1'b1, MODE_CLEAR, 8'h00, 1'b0);

    // Enable gating
    step(1'b1, MODE_SHIFT, 8'd1, 1'b1);
    step(1'b1, MODE_SHIFT, 8'd2, 1'b1);
    step(1'b1, MODE_SHIFT, 8'd3, 1'b1);
    step(1'b1, MODE_SHIFT, 8'd4, 1'b1);
    chk_all("gate_fill", 8'd1, 1'b1, 3'd4, 1'b1, 1'b0);
    step(1'b0, MODE_SHIFT, 8'hEE, 1'b1);
    step(1'b0, MODE_CLEAR, 8'hEE, 1'b1);
    step(1'b0, MODE_SHIFT, 8'hEE, 1'b0);
    chk_all("gate_hold", 8'd1, 1'b1, 3'd4, 1'b1, 1'b0);
    step(1'b1, MODE_SHIFT, 8'd5, 1'b1);
    chk_all("gate_resume", 8'd2, 1'b1, 3'd4, 1'b1, 1'b0);

    // Async reset with stages preloaded, before any edge
    step(1'b1, MODE_LOAD, 8'h3C, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_rst", 8'h00, 1'b0, 3'd0, 1'b0, 1'b1);

    // Reset mid-stream: held 2 cycles while shifting is requested
    step(1'b1, MODE_SHIFT, 8'h11, 1'b1);
    step(1'b1, MODE_SHIFT, 8'h22, 1'b1);
    chk_all("rst_held", 8'h00, 1'b0, 3'd0, 1'b0, 1'b1);
    #2 rst_n = 1'b1;
    bus.en = 1'b0;
    @(negedge clk);
    step(1'b1, MODE_SHIFT, 8'h33, 1'b1);
    chk_all("post_rst", 8'h00, 1'b0, 3'd1, 1'b0, 1'b0);
    step(1'b1, MODE_SHIFT, 8'h44, 1'b1);
    step(1'b1, MODE_SHIFT, 8'h55, 1'b1);
    step(1'b1, MODE_SHIFT, 8'h66, 1'b1);
    chk_all("post_rst_q", 8'h33, 1'b1, 3'd4, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
